// File: rtl/canvas_renderer_if.sv
// canvas_renderer_if: draw-command valid/ready bundle
// master drives commands, slave (the renderer) returns cmd_ready
interface canvas_renderer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_x;
  logic [7:0] cmd_y;
  logic [2:0] cmd_color;
  logic [1:0] cmd_size;
  logic       cmd_clear;

  modport master (
    output cmd_valid, cmd_x, cmd_y,
    output cmd_color, cmd_size, cmd_clear,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_x, cmd_y,
    input  cmd_color, cmd_size, cmd_clear,
    output cmd_ready
  );
endinterface

// File: rtl/canvas_renderer.sv
// canvas_renderer: scaled cell canvas with VGA timing and brush/clear engine
// Optional cursor overlay enabled by defining CURSOR_OVERLAY_EN
module canvas_renderer #(
  parameter int CANVAS_W = 160,
  parameter int CANVAS_H = 120,
  parameter int SCALE    = 4,
  parameter int DAC_BITS = 4,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic                clk,
  input  logic                reset_n,
  canvas_renderer_if.slave    cmd,
  output logic                hsync,
  output logic                vsync,
  output logic [DAC_BITS-1:0] r,
  output logic [DAC_BITS-1:0] g,
  output logic [DAC_BITS-1:0] b,
  output logic                frame_start
);

  localparam int H_ACT = CANVAS_W * SCALE;
  localparam int V_ACT = CANVAS_H * SCALE;
  localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);
  localparam int CELLS = CANVAS_W * CANVAS_H;
  localparam int AW    = $clog2(CELLS);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_ACTL = HW'(H_ACT);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACT + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACT + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_ACTL = VW'(V_ACT);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACT + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACT + V_FP + V_SYNC);
  localparam logic [AW-1:0] A_LAST = AW'(CELLS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STAMP,
    S_CLEAR
  } state_t;

  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic [HW-1:0] w_hc;
  logic [VW-1:0] w_vc;
  logic          w_act0;
  logic          w_hs0;
  logic          w_vs0;
  logic          w_fs0;
  logic [AW-1:0] w_raddr;

  logic [AW-1:0] r_raddr;
  logic          r_act1, r_hs1, r_vs1, r_fs1;
  logic          r_act2, r_hs2, r_vs2, r_fs2;
  logic [2:0]    r_rd;
  logic [2:0]    w_code;
  logic [2:0]    w_rgb;
  logic [2:0]    r_mem [CELLS];

  state_t        r_state, w_next;
  logic          r_armed;
  logic          w_ready;
  logic          w_accept;
  logic [7:0]    r_cx, r_cy;
  logic [2:0]    r_col;
  logic [1:0]    r_n;
  logic [2:0]    r_dx, r_dy;
  logic [2:0]    w_n3, w_negn;
  logic [AW-1:0] r_caddr;
  logic [9:0]    w_sx, w_sy;
  logic          w_in;
  logic [AW-1:0] w_saddr;
  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic [2:0]    w_wdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_h <= '0;
      r_v <= '0;
    end else if (r_h == H_LAST) begin
      r_h <= '0;
      r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
    end else begin
      r_h <= r_h + 1'b1;
    end
  end

  always_comb begin
    w_hc    = r_h / HW'(SCALE);
    w_vc    = r_v / VW'(SCALE);
    w_act0  = (r_h < H_ACTL) && (r_v < V_ACTL);
    w_hs0   = !((r_h >= HS_BEG) && (r_h < HS_END));
    w_vs0   = !((r_v >= VS_BEG) && (r_v < VS_END));
    w_fs0   = (r_h == '0) && (r_v == '0);
    w_raddr = '0;
    if (w_act0)
      w_raddr = AW'(32'(w_vc) * CANVAS_W + 32'(w_hc));
  end

  // syncs and blank travel alongside the address/read stages
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_raddr <= '0;
      r_act1  <= 1'b0;
      r_hs1   <= 1'b1;
      r_vs1   <= 1'b1;
      r_fs1   <= 1'b0;
      r_act2  <= 1'b0;
      r_hs2   <= 1'b1;
      r_vs2   <= 1'b1;
      r_fs2   <= 1'b0;
    end else begin
      r_raddr <= w_raddr;
      r_act1  <= w_act0;
      r_hs1   <= w_hs0;
      r_vs1   <= w_vs0;
      r_fs1   <= w_fs0;
      r_act2  <= r_act1;
      r_hs2   <= r_hs1;
      r_vs2   <= r_vs1;
      r_fs2   <= r_fs1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we)
      r_mem[w_waddr] <= w_wdata;
    r_rd <= r_mem[r_raddr];
  end

`ifdef CURSOR_OVERLAY_EN
  logic [7:0] r_cur_x, r_cur_y;
  logic       r_cur1, r_cur2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cur_x <= '0;
      r_cur_y <= '0;
      r_cur1  <= 1'b0;
      r_cur2  <= 1'b0;
    end else begin
      if (w_accept && !cmd.cmd_clear) begin
        r_cur_x <= cmd.cmd_x;
        r_cur_y <= cmd.cmd_y;
      end
      r_cur1 <= (32'(w_hc) == 32'(r_cur_x)) &&
                (32'(w_vc) == 32'(r_cur_y));
      r_cur2 <= r_cur1;
    end
  end

  assign w_code = r_rd ^ {3{r_cur2}};
`else
  assign w_code = r_rd;
`endif

  always_comb begin
    w_rgb = 3'b000;
    unique case (w_code)
      3'd0: w_rgb = 3'b000;
      3'd1: w_rgb = 3'b111;
      3'd2: w_rgb = 3'b100;
      3'd3: w_rgb = 3'b010;
      3'd4: w_rgb = 3'b001;
      3'd5: w_rgb = 3'b110;
      3'd6: w_rgb = 3'b011;
      3'd7: w_rgb = 3'b101;
    endcase
    if (!r_act2)
      w_rgb = 3'b000;
  end

  assign r           = {DAC_BITS{w_rgb[2]}};
  assign g           = {DAC_BITS{w_rgb[1]}};
  assign b           = {DAC_BITS{w_rgb[0]}};
  assign hsync       = r_hs2;
  assign vsync       = r_vs2;
  assign frame_start = r_fs2;

  assign w_ready       = (r_state == S_IDLE) && r_armed;
  assign cmd.cmd_ready = w_ready;
  assign w_accept      = cmd.cmd_valid && w_ready;

  // brush offsets are 3-bit two's complement, extended before adding
  assign w_n3    = {1'b0, r_n};
  assign w_negn  = 3'd0 - w_n3;
  assign w_sx    = {2'b00, r_cx} + {{7{r_dx[2]}}, r_dx};
  assign w_sy    = {2'b00, r_cy} + {{7{r_dy[2]}}, r_dy};
  assign w_in    = !w_sx[9] && !w_sy[9] &&
                   (w_sx[8:0] < 9'(CANVAS_W)) &&
                   (w_sy[8:0] < 9'(CANVAS_H));
  assign w_saddr = AW'(32'(w_sy[8:0]) * CANVAS_W +
                       32'(w_sx[8:0]));

  always_comb begin
    w_next  = r_state;
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = r_col;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept)
          w_next = cmd.cmd_clear ? S_CLEAR : S_STAMP;
      end
      S_STAMP: begin
        w_we    = w_in;
        w_waddr = w_saddr;
        if ((r_dx == w_n3) && (r_dy == w_n3))
          w_next = S_IDLE;
      end
      S_CLEAR: begin
        w_we    = 1'b1;
        w_waddr = r_caddr;
        if (r_caddr == A_LAST)
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_armed <= 1'b0;
      r_cx    <= '0;
      r_cy    <= '0;
      r_col   <= '0;
      r_n     <= '0;
      r_dx    <= '0;
      r_dy    <= '0;
      r_caddr <= '0;
    end else begin
      r_armed <= 1'b1;
      if (w_accept) begin
        r_cx    <= cmd.cmd_x;
        r_cy    <= cmd.cmd_y;
        r_col   <= cmd.cmd_color;
        r_n     <= cmd.cmd_size;
        r_dx    <= 3'd0 - {1'b0, cmd.cmd_size};
        r_dy    <= 3'd0 - {1'b0, cmd.cmd_size};
        r_caddr <= '0;
      end else if (r_state == S_STAMP) begin
        if (r_dx == w_n3) begin
          r_dx <= w_negn;
          r_dy <= r_dy + 3'd1;
        end else begin
          r_dx <= r_dx + 3'd1;
        end
      end else if (r_state == S_CLEAR) begin
        r_caddr <= r_caddr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_canvas_renderer.sv
// tb_canvas_renderer: random brush/clear commands against a cell-array model
// Video is checked pixel by pixel from timing arithmetic and the model canvas
module tb_canvas_renderer;

  localparam int W   = 24;
  localparam int H   = 24;
  localparam int S   = 2;
  localparam int DB  = 4;
  localparam int HFP = 4;
  localparam int HSW = 8;
  localparam int HBP = 6;
  localparam int VFP = 2;
  localparam int VSW = 2;
  localparam int VBP = 3;
  localparam int HA  = W * S;
  localparam int VA  = H * S;
  localparam int HT  = HA + HFP + HSW + HBP;
  localparam int VT  = VA + VFP + VSW + VBP;
  localparam int FR  = HT * VT;
  localparam int LIM = 30000;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          hsync, vsync, frame_start;
  logic [DB-1:0] r, g, b;

  canvas_renderer_if cif ();

  canvas_renderer #(
    .CANVAS_W(W), .CANVAS_H(H), .SCALE(S), .DAC_BITS(DB),
    .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .cmd(cif.slave),
    .hsync(hsync),
    .vsync(vsync),
    .r(r),
    .g(g),
    .b(b),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int edges;
  logic [2:0] model [W*H];
  int cur_x, cur_y;

  always @(posedge clk or negedge reset_n)
    if (!reset_n) edges <= 0;
    else          edges <= edges + 1;

  function automatic logic [2:0] pal(input logic [2:0] c);
    case (c)
      3'd0: return 3'b000;
      3'd1: return 3'b111;
      3'd2: return 3'b100;
      3'd3: return 3'b010;
      3'd4: return 3'b001;
      3'd5: return 3'b110;
      3'd6: return 3'b011;
      default: return 3'b101;
    endcase
  endfunction

  task automatic apply_model(input int x, input int y, input int c,
                             input int n, input bit clr, input int lim);
    int k;
    if (clr) begin
      for (int i = 0; i < W*H; i++) model[i] = 3'(c);
    end else begin
      cur_x = x;
      cur_y = y;
      k = 0;
      for (int dy = -n; dy <= n; dy++)
        for (int dx = -n; dx <= n; dx++) begin
          if (k < lim && x+dx >= 0 && x+dx < W && y+dy >= 0 && y+dy < H)
            model[(y+dy)*W + x+dx] = 3'(c);
          k++;
        end
    end
  endtask

  task automatic check_frame(input bit chk_rgb, input string nm);
    int errs, fs, p, ox, oy;
    logic ehs, evs, efs, act;
    logic [2:0] code, rgb;
    logic [3*DB-1:0] exp_rgb;
    string first;
    errs = 0; fs = 0; first = "";
    for (int i = 0; i < FR; i++) begin
      @(negedge clk);
      p   = (edges - 2) % FR;
      ox  = p % HT;
      oy  = p / HT;
      ehs = !(ox >= HA+HFP && ox < HA+HFP+HSW);
      evs = !(oy >= VA+VFP && oy < VA+VFP+VSW);
      efs = (p == 0);
      act = (ox < HA) && (oy < VA);
      if (frame_start === 1'b1) fs++;
      rgb = 3'b000;
      if (act) begin
        code = model[(oy/S)*W + ox/S];
`ifdef CURSOR_OVERLAY_EN
        if (ox/S == cur_x && oy/S == cur_y) code = code ^ 3'd7;
`endif
        rgb = pal(code);
      end
      exp_rgb = {{DB{rgb[2]}}, {DB{rgb[1]}}, {DB{rgb[0]}}};
      if (hsync !== ehs || vsync !== evs || frame_start !== efs ||
          ((chk_rgb || !act) && {r, g, b} !== exp_rgb)) begin
        if (errs == 0)
          first = $sformatf("at (%0d,%0d) got hs=%b vs=%b fs=%b rgb=%h want hs=%b vs=%b fs=%b rgb=%h",
                            ox, oy, hsync, vsync, frame_start, {r, g, b},
                            ehs, evs, efs, exp_rgb);
        errs++;
      end
    end
    n_checks++;
    if (errs !== 0) begin
      n_fail++;
      $display("FAIL %s video: %0d bad pixels, first %s", nm, errs, first);
    end
    n_checks++;
    if (fs !== 1) begin
      n_fail++;
      $display("FAIL %s frame_start count: got %0d want 1", nm, fs);
    end
  endtask

  task automatic send_cmd(input int x, input int y, input int c, input int n,
                          input bit clr, input bit hold, input string nm);
    int t, busy, expb;
    t = 0;
    @(negedge clk);
    while (cif.cmd_ready !== 1'b1 && t < LIM) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (cif.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready-wait: cmd_ready=%b want 1", nm, cif.cmd_ready);
    end
    cif.cmd_x     = 8'(x);
    cif.cmd_y     = 8'(y);
    cif.cmd_color = 3'(c);
    cif.cmd_size  = 2'(n);
    cif.cmd_clear = clr;
    cif.cmd_valid = 1'b1;
    @(posedge clk);
    apply_model(x, y, c, n, clr, 1 << 30);
    busy = 0;
    @(negedge clk);
    if (!hold) cif.cmd_valid = 1'b0;
    while (cif.cmd_ready !== 1'b1 && busy < LIM) begin
      busy++;
      cif.cmd_x     = 8'($urandom);
      cif.cmd_y     = 8'($urandom);
      cif.cmd_color = 3'($urandom);
      cif.cmd_size  = 2'($urandom);
      cif.cmd_clear = 1'($urandom);
      @(negedge clk);
    end
    cif.cmd_valid = 1'b0;
    expb = clr ? W*H : (2*n+1)*(2*n+1);
    n_checks++;
    if (busy !== expb) begin
      n_fail++;
      $display("FAIL %s busy cycles: got %0d want %0d", nm, busy, expb);
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    n_checks++;
    if (hsync !== 1'b1 || vsync !== 1'b1) begin
      n_fail++;
      $display("FAIL %s syncs: got %b%b want 11", nm, hsync, vsync);
    end
    n_checks++;
    if ({r, g, b, frame_start} !== '0) begin
      n_fail++;
      $display("FAIL %s rgb/fs: got %h/%b want 0/0", nm, {r, g, b}, frame_start);
    end
    n_checks++;
    if (cif.cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s cmd_ready: got %b want 0", nm, cif.cmd_ready);
    end
  endtask

  task automatic release_and_check(input string nm);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_checks++;
    if (cif.cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s ready before edge: got %b want 0", nm, cif.cmd_ready);
    end
    @(negedge clk);
    n_checks++;
    if (cif.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready after edge: got %b want 1", nm, cif.cmd_ready);
    end
  endtask

  task automatic test_reset();
    reset_n       = 1'b0;
    cif.cmd_valid = 1'b0;
    cif.cmd_x     = '0;
    cif.cmd_y     = '0;
    cif.cmd_color = '0;
    cif.cmd_size  = '0;
    cif.cmd_clear = 1'b0;
    cur_x = 0;
    cur_y = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    release_and_check("reset");
  endtask

  task automatic test_timing();
    check_frame(1'b0, "timing");
  endtask

  task automatic test_clear_hold();
    int low;
    send_cmd($urandom_range(0, 255), $urandom_range(0, 255), 1,
             $urandom_range(0, 3), 1'b1, 1'b1, "clear-white");
    low = 0;
    repeat (8) begin
      @(negedge clk);
      if (cif.cmd_ready !== 1'b1) low++;
    end
    n_checks++;
    if (low !== 0) begin
      n_fail++;
      $display("FAIL clear-white no-queue: ready low %0d cycles want 0", low);
    end
    check_frame(1'b1, "clear-white");
  endtask

  task automatic test_single_cell();
    send_cmd(0, 0, 0, 0, 1'b1, 1'b0, "clear-black");
    send_cmd(10, 20, 2, 0, 1'b0, 1'b0, "dot");
    check_frame(1'b1, "dot");
  endtask

  task automatic test_corner();
    send_cmd(0, 0, 4, 1, 1'b0, 1'b0, "corner");
    send_cmd(W-1, H-1, 6, 2, 1'b0, 1'b1, "far-corner");
    send_cmd(254, 3, 5, 3, 1'b0, 1'b0, "no-wrap");
    check_frame(1'b1, "corners");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 14; i++)
      send_cmd($urandom_range(0, W+3), $urandom_range(0, H+3),
               $urandom_range(0, 7), $urandom_range(0, 3),
               ($urandom_range(0, 15) == 0), 1'($urandom), "random");
    check_frame(1'b1, "random");
  endtask

  task automatic test_reset_mid_stamp();
    int t, low;
    t = 0;
    @(negedge clk);
    while (cif.cmd_ready !== 1'b1 && t < LIM) begin
      @(negedge clk);
      t++;
    end
    cif.cmd_x     = 8'd8;
    cif.cmd_y     = 8'd8;
    cif.cmd_color = 3'd5;
    cif.cmd_size  = 2'd3;
    cif.cmd_clear = 1'b0;
    cif.cmd_valid = 1'b1;
    @(posedge clk);
    apply_model(8, 8, 5, 3, 1'b0, 10);
    #1 cif.cmd_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check_reset_outputs("mid-stamp");
    cur_x = 0;
    cur_y = 0;
    @(negedge clk);
    release_and_check("mid-stamp");
    low = 0;
    repeat (60) begin
      @(negedge clk);
      if (cif.cmd_ready !== 1'b1) low++;
    end
    n_checks++;
    if (low !== 0) begin
      n_fail++;
      $display("FAIL mid-stamp resumed: ready low %0d cycles want 0", low);
    end
    check_frame(1'b1, "mid-stamp");
  endtask

`ifdef CURSOR_OVERLAY_EN
  task automatic test_cursor();
    send_cmd(0, 0, 3, 0, 1'b1, 1'b0, "cursor-clear");
    send_cmd(5, 5, 3, 0, 1'b0, 1'b0, "cursor");
    check_frame(1'b1, "cursor");
  endtask
`endif

  initial begin
    test_reset();
    test_timing();
    test_clear_hold();
    test_single_cell();
    test_corner();
    test_back_to_back();
    test_reset_mid_stamp();
`ifdef CURSOR_OVERLAY_EN
    test_cursor();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
